// File: rtl/display_pkg.sv
// Shared constants for the display scan controller: scan FSM encodings,
// nibble width and the inactive level of the active-low digit enables.
package display_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  localparam int   NIBBLE_W = 4;
  localparam logic AN_OFF   = 1'b1;

endpackage

// File: rtl/refresh_divider.sv
// Slot-length counter for the scan controller: counts enabled cycles
// 0..DIV-1 and flags the terminal count; synchronous clear has priority.
module refresh_divider #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_count;

  assign o_tc = (r_count == CW'(DIV - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_tc ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-synchronous double buffering.
// Optional LEADING_ZERO_BLANK_EN macro suppresses enables of leading zero digits.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           load,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] digits_in,
  input  logic                           ovf_in,
  output logic [NIBBLE_W-1:0]            bi_digit,
  output logic                           overflow,
  output logic [NUM_DIGITS-1:0]          an,
  output logic                           pending,
  output logic                           frame_done
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = NIBBLE_W * NUM_DIGITS;

  scan_state_t         r_state, w_state_next;
  logic [IW-1:0]       r_idx, w_idx_next;
  logic [DW-1:0]       r_pend_data, r_disp_data;
  logic                r_pend_ovf, r_disp_ovf, r_pending, r_frame_done;
  logic                w_tc, w_div_clr, w_div_en, w_wrap;
  logic [NIBBLE_W-1:0] w_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] w_lz_blank;

  assign w_div_clr = (r_state == BLANK);
  assign w_div_en  = (r_state == DRIVE);

  refresh_divider #(
    .DIV(REFRESH_DIV)
  ) u_refresh_divider (
    .clk   (clk),
    .resetn(resetn),
    .i_clr (w_div_clr),
    .i_en  (w_div_en),
    .o_tc  (w_tc)
  );

  assign w_wrap = (r_state == DRIVE) && w_tc && (r_idx == IW'(NUM_DIGITS - 1));

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign w_nib[gi] = r_disp_data[gi*NIBBLE_W +: NIBBLE_W];
`ifdef LEADING_ZERO_BLANK_EN
      if (gi == 0) begin : g_first
        assign w_lz_blank[gi] = 1'b0;
      end else begin : g_upper
        // Blank only when this digit and everything above it is zero.
        assign w_lz_blank[gi] = !r_disp_ovf && (r_disp_data[DW-1:gi*NIBBLE_W] == '0);
      end
`else
      assign w_lz_blank[gi] = 1'b0;
`endif
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= BLANK;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    an           = {NUM_DIGITS{AN_OFF}};
    case (r_state)
      BLANK: w_state_next = DRIVE;
      DRIVE: begin
        if (!w_lz_blank[r_idx]) an[r_idx] = ~AN_OFF;
        if (w_tc) begin
          w_state_next = BLANK;
          w_idx_next   = (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end
      end
      default: w_state_next = BLANK;
    endcase
  end

  // A load on the wrap edge lands after the commit, so it stays pending.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pend_data  <= '0;
      r_pend_ovf   <= 1'b0;
      r_pending    <= 1'b0;
      r_disp_data  <= '0;
      r_disp_ovf   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_wrap;
      if (w_wrap && r_pending) begin
        r_disp_data <= r_pend_data;
        r_disp_ovf  <= r_pend_ovf;
        r_pending   <= 1'b0;
      end
      if (load) begin
        r_pend_data <= digits_in;
        r_pend_ovf  <= ovf_in;
        r_pending   <= 1'b1;
      end
    end
  end

  assign bi_digit   = w_nib[r_idx];
  assign overflow   = r_disp_ovf;
  assign pending    = r_pending;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (NUM_DIGITS=4, REFRESH_DIV=3):
// scan tables, a slot scoreboard, and hand-written wrap/reset sequences.
module tb_display_scan_ctrl;

  localparam int ND  = 4;
  localparam int DIV = 3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic        ovf_in = 1'b0;
  logic [3:0]  bi_digit;
  logic        overflow;
  logic [3:0]  an;
  logic        pending;
  logic        frame_done;

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(DIV)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .load      (load),
    .digits_in (digits_in),
    .ovf_in    (ovf_in),
    .bi_digit  (bi_digit),
    .overflow  (overflow),
    .an        (an),
    .pending   (pending),
    .frame_done(frame_done)
  );

  typedef struct {
    logic [3:0] an_exp;
    logic       fd_exp;
    logic [3:0] bi_exp;
  } vec_t;

  typedef struct {
    logic [15:0] din;
    logic        oin;
    logic [15:0] show;
    logic        show_ovf;
  } scen_t;

  typedef struct {
    logic [1:0] idx;
    logic [3:0] nib;
    logic       ovf;
  } exp_t;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  exp_t       sb[$];
  logic [3:0] prev_an = 4'hF;
  logic [3:0] prev_bi = 4'h0;

  vec_t  scan_tbl[16];
  vec_t  lz_tbl[16];
  scen_t scen[3];
  logic [3:0] an_pat[16];
  logic [3:0] lz_an_pat[16];
  logic [3:0] lz_bi_pat[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    if (prev_an == 4'hF && an !== 4'hF && sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("slot_an", 32'(an), 32'(4'hF & ~(4'h1 << e.idx)));
      check("slot_digit", 32'(bi_digit), 32'(e.nib));
      check("slot_ovf", 32'(overflow), 32'(e.ovf));
      check("ghost_guard", 32'(prev_bi), 32'(bi_digit));
      $display("[TB] slot %0d an=%h digit=%h ovf=%0b", e.idx, an, bi_digit, overflow);
    end
    prev_an = an;
    prev_bi = bi_digit;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    monitor();
  endtask

  task automatic wait_fd();
    int n = 0;
    while (frame_done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("frame_done_seen", 32'(frame_done), 32'd1);
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb.size() > 0 && n < 40) begin
      tick();
      n++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic push_frame(input logic [15:0] d, input logic o);
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.idx = 2'(i);
      e.nib = d[4*i +: 4];
      e.ovf = o;
      sb.push_back(e);
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic o);
    load      = 1'b1;
    digits_in = d;
    ovf_in    = o;
    $display("[TB] load %h ovf=%0b at cycle %0d", d, o, cyc);
    tick();
    load = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 resetn = 1'b1;
    @(negedge clk);
    cyc     = 0;
    prev_an = an;
    prev_bi = bi_digit;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
`ifdef LEADING_ZERO_BLANK_EN
    an_pat    = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hF, 4'hF,
                  4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    lz_an_pat = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                  4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
`else
    an_pat    = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                  4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};
    lz_an_pat = an_pat;
`endif
    lz_bi_pat = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h5, 4'h5, 4'h5, 4'h5,
                  4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    for (int f = 0; f < 16; f++) begin
      scan_tbl[f] = '{an_exp: an_pat[f], fd_exp: (f == 0), bi_exp: 4'h0};
      lz_tbl[f]   = '{an_exp: lz_an_pat[f], fd_exp: (f == 0), bi_exp: lz_bi_pat[f]};
    end
    scen[0] = '{din: 16'h1234, oin: 1'b0, show: 16'h1234, show_ovf: 1'b0};
    scen[1] = '{din: 16'h9876, oin: 1'b1, show: 16'h9876, show_ovf: 1'b1};
    scen[2] = '{din: 16'h70F0, oin: 1'b0, show: 16'h70F0, show_ovf: 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_an", 32'(an), 32'hF);
    check("rst_bi", 32'(bi_digit), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    $display("[TB] reset state checked");

    // Scan pattern over two full frames plus the next wrap
    release_reset();
    for (int c = 0; c <= 32; c++) begin
      check("scan_an", 32'(an), 32'(scan_tbl[c % 16].an_exp));
      check("scan_frame_done", 32'(frame_done), 32'(scan_tbl[c % 16].fd_exp && c > 0));
      check("scan_bi", 32'(bi_digit), 32'(scan_tbl[c % 16].bi_exp));
      tick();
    end
    $display("[TB] scan pattern checked through cycle %0d", cyc);

    // Mid-frame loads committed at the next wrap
    for (int i = 0; i < 3; i++) begin
      do_load(scen[i].din, scen[i].oin);
      check("pending_rise", 32'(pending), 32'd1);
      if (i == 0) check("display_unchanged", 32'(bi_digit), 32'h0);
      wait_fd();
      check("pending_clear", 32'(pending), 32'd0);
      push_frame(scen[i].show, scen[i].show_ovf);
      wait_empty();
    end

    // Two loads before one wrap: latest wins
    do_load(16'h1111, 1'b0);
    do_load(16'hABCD, 1'b0);
    check("pending_overwrite", 32'(pending), 32'd1);
    wait_fd();
    check("pending_clear_abcd", 32'(pending), 32'd0);
    push_frame(16'hABCD, 1'b0);
    wait_empty();

    // Load landing exactly on the wrap edge (last DRIVE cycle of digit 3)
    do_load(16'h1234, 1'b0);
    tick();
    check("pre_wrap_an", 32'(an), 32'h7);
    do_load(16'h5555, 1'b0);
    check("wrap_frame_done", 32'(frame_done), 32'd1);
    check("wrap_pending_kept", 32'(pending), 32'd1);
    push_frame(16'h1234, 1'b0);
    wait_empty();
    wait_fd();
    check("wrap_pending_clear", 32'(pending), 32'd0);
    push_frame(16'h5555, 1'b0);
    wait_empty();

    // Asynchronous reset in the middle of digit 2's DRIVE slot
    wait_fd();
    repeat (8) tick();
    do_load(16'h00C0, 1'b0);
    check("pre_rst_an", 32'(an), 32'hB);
    check("pre_rst_bi", 32'(bi_digit), 32'h5);
    check("pre_rst_pending", 32'(pending), 32'd1);
    #1 resetn = 1'b0;
    #1;
    check("async_rst_an", 32'(an), 32'hF);
    check("async_rst_bi", 32'(bi_digit), 32'h0);
    check("async_rst_pending", 32'(pending), 32'd0);
    check("async_rst_ovf", 32'(overflow), 32'd0);
    check("async_rst_frame_done", 32'(frame_done), 32'd0);
    $display("[TB] async reset mid-DRIVE checked");

    // Small value: leading-zero digits (blanked only when the macro is defined)
    release_reset();
    do_load(16'h0050, 1'b0);
    check("lz_pending", 32'(pending), 32'd1);
    wait_fd();
    for (int f = 0; f < 16; f++) begin
      check("lz_an", 32'(an), 32'(lz_tbl[f].an_exp));
      check("lz_bi", 32'(bi_digit), 32'(lz_tbl[f].bi_exp));
      tick();
    end
    $display("[TB] leading-zero frame checked");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexed scan controller that shares one 7-segment decoder among NUM_DIGITS digit positions. Double-buffers a multi-digit value plus an overflow flag, commits new values only at frame boundaries (no tearing), and drives the decoder's `bi_digit`/`overflow` inputs and the active-low digit enables. It sits between the arithmetic datapath result register and the existing hex/overflow 7-segment decoder at the board top level.

## Interface
- NUM_DIGITS, 4, digit positions scanned; legal 1..8
- REFRESH_DIV, 50000, clk cycles per digit DRIVE slot; legal >= 1
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- load  in  1  1-cycle strobe: capture `digits_in`/`ovf_in` into the pending buffer
- digits_in  in  4*NUM_DIGITS  packed nibbles; [3:0] = digit 0 (least significant)
- ovf_in  in  1  overflow flag captured with `digits_in`
- bi_digit  out  4  nibble to shared decoder
- overflow  out  1  overflow to shared decoder (decoder shows dash)
- an  out  NUM_DIGITS  digit enables, active-low, at most one low
- pending  out  1  pending buffer holds an uncommitted value
- frame_done  out  1  1-cycle pulse when the scan wraps to digit 0

## Operation
- Registers: pending buffer (data, ovf, `pending`), display buffer (data, ovf), digit index, refresh counter, FSM state.
- FSM states: BLANK, DRIVE.
  - BLANK: `an` all ones; `bi_digit`/`overflow` present display-buffer nibble for current index; lasts exactly 1 cycle, then DRIVE with counter cleared.
  - DRIVE: `an[index]` low; counter increments; at count REFRESH_DIV-1 → BLANK, index+1 (NUM_DIGITS-1 wraps to 0).
- Wrap (DRIVE terminal at index NUM_DIGITS-1): `frame_done` pulses in the following BLANK cycle; if `pending`=1, display buffer ← pending buffer and `pending` ← 0 on that same edge.
- `load`: pending buffer ← inputs, `pending` ← 1 on next edge. Load while pending=1 overwrites (latest wins).
- Load on the wrap edge: old pending value commits; new value captured, `pending` stays 1, commits next frame.
- Display ovf=1: `overflow`=1 in every slot; `bi_digit` still carries the nibble.
- All outputs decoded from registers only; no combinational input→output path.
- Reset (async assert, any state): state BLANK, index 0, counter 0, both buffers 0, `pending`=0, `an` all ones, `bi_digit`=0, `overflow`=0, `frame_done`=0.

## Timing
- Slot = 1 BLANK + REFRESH_DIV DRIVE cycles; frame = NUM_DIGITS*(REFRESH_DIV+1) cycles.
- First cycle after reset release is BLANK index 0; `an[0]` low from the second cycle.
- `pending` rises 1 cycle after `load`. Load-to-display latency: 1 cycle to at most 1 frame + 1 cycle.
- `bi_digit` settles in BLANK, one cycle before the enable asserts (ghosting guard).

## Configuration
- LEADING_ZERO_BLANK_EN defined: during DRIVE of digit i (i>0), `an[i]` stays high if digits i..NUM_DIGITS-1 of the display buffer are all zero; digit 0 always lit; disabled when display ovf=1. Slot timing unchanged.
- Undefined: every digit lit in its slot.

## Structure
- Shared package/header `display_pkg`: FSM state encodings (BLANK, DRIVE), nibble width constant 4, enable-inactive level constant.
- Sub-module `refresh_divider`: parameterized counter with synchronous clear and terminal-count flag; FSM and buffers stay in the top module. The decoder remains external.

## Test plan
- NUM_DIGITS=4, REFRESH_DIV=3, reset → `an`=4'hF, outputs 0; after release `an` = F,E,E,E,F,D,D,D,F,B,B,B,F,7,7,7 repeating; `frame_done` at cycle 16, 32.
- Mid-frame load 16'h1234, ovf 0 → `pending`=1 next cycle; display unchanged until wrap; then slots show 4,3,2,1, `pending`=0.
- Loads 16'h1111 then 16'hABCD before wrap → only A,B,C,D sequence displayed (slots D,C,B,A).
- Load 16'h5555 on wrap edge while 16'h1234 pending → 1234 displayed this frame, `pending`=1, 5555 displayed next frame; ovf_in=1 load → `overflow`=1 in all four slots.
- Assert `resetn`=0 mid-DRIVE of digit 2 without clock edge → `an`=4'hF, `bi_digit`=0, `pending`=0 immediately.
- LEADING_ZERO_BLANK_EN, display 16'h0050 → slots 0,1 lit (0,5); `an` stays 4'hF through slots 2,3.
